// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Results are computed at issue and committed when the latency counter expires.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic        is_mul;
    logic        is_div;
    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] prod;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] dv;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:   is_div = 1'b1;
            default: ;
        endcase
    end

    // Signed ops run on magnitudes; signs are restored afterwards,
    // which also makes 0x80000000 / -1 wrap to 0x80000000 cleanly.
    always_comb begin
        sgn    = (op == OP_MULT) || (op == OP_DIV);
        neg_a  = sgn & a[31];
        neg_b  = sgn & b[31];
        prod   = {{32{neg_a}}, a} * {{32{neg_b}}, b};
        ua     = neg_a ? -a : a;
        ub     = neg_b ? -b : b;
        dv     = (ub == 32'd0) ? 32'd1 : ub;
        uq     = ua / dv;
        ur     = ua % dv;
        res_hi = neg_a ? -ur : ur;
        res_lo = (neg_a ^ neg_b) ? -uq : uq;
        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (b == 32'd0) begin
            res_hi = hi;
            res_lo = lo;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && (is_mul || is_div)) state_d = RUN;
            RUN:  if (cnt == 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (start && (is_mul || is_div)) begin
                    cnt     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                end
                if (start && op == OP_MTHI) hi <= a;
                if (start && op == OP_MTLO) lo <= a;
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed table, corner sequences, and a
// randomized run against an arithmetic reference model.
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        rd_sel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .rd_sel(rd_sel), .busy(busy),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MC;
        if (o == 3'd3 || o == 3'd4) return DC;
        return 0;
    endfunction

    task automatic model(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] oh,
                         input logic [31:0] ol,
                         output logic [31:0] nh, output logic [31:0] nl);
        int          xi;
        int          yi;
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] u;
        xi = x;
        yi = y;
        sx = xi;
        sy = yi;
        nh = oh;
        nl = ol;
        case (o)
            3'd1: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; end
            3'd2: begin
                u = 64'(x) * 64'(y);
                nh = u[63:32];
                nl = u[31:0];
            end
            3'd3: if (y != 0) begin
                p = sx / sy;
                nl = p[31:0];
                p = sx % sy;
                nh = p[31:0];
            end
            3'd4: if (y != 0) begin nl = x / y; nh = x % y; end
            3'd5: nh = x;
            3'd6: nl = x;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'd0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh,
                          input logic [31:0] el, input string name);
        int n;
        n = lat(o);
        issue(o, x, y);
        for (int i = 0; i < n; i++) begin
            chk({name, " busy"}, 32'(busy), 32'd1);
            chk({name, " hi hold"}, hi, m_hi);
            chk({name, " lo hold"}, lo, m_lo);
            @(posedge clk);
            #1;
        end
        chk({name, " busy end"}, 32'(busy), 32'd0);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        chk({name, " rd lo"}, rd_data, el);
        m_hi = eh;
        m_lo = el;
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vt.push_back('{3'd1, 32'hFFFFFFFE, 32'h3,
                       32'hFFFFFFFF, 32'hFFFFFFFA, "mult -2*3"});
        vt.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                       32'hFFFFFFFE, 32'h1, "multu max"});
        vt.push_back('{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7"});
        vt.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,
                       32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"});
        vt.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF,
                       32'h0, 32'h80000000, "div ovf"});
        vt.push_back('{3'd5, 32'h11, 32'h0, 32'h11, 32'h80000000, "mthi"});
        vt.push_back('{3'd6, 32'h22, 32'h0, 32'h11, 32'h22, "mtlo"});

        #2;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // async reset mid-cycle after loading hi
        run_op(3'd5, 32'h55, 32'd0, 32'h55, 32'd0, "pre mthi");
        #2;
        reset = 1'b0;
        #1;
        chk("async hi", hi, 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 0;
        m_lo = 0;

        // abort a mult in flight
        issue(3'd1, 32'd3, 32'd4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort busy late", 32'(busy), 32'd0);

        foreach (vt[i])
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
                   vt[i].name);

        // divide by zero with a mult issued mid-run
        issue(3'd3, 32'd5, 32'd0);
        for (int i = 0; i < DC; i++) begin
            chk("dz busy", 32'(busy), 32'd1);
            if (i == 3) begin
                @(negedge clk);
                start = 1'b1;
                op = 3'd1;
                a = 32'd9;
                b = 32'd9;
                @(posedge clk);
                #1;
                start = 1'b0;
                op = 3'd0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("dz busy end", 32'(busy), 32'd0);
        chk("dz hi", hi, 32'h11);
        chk("dz lo", lo, 32'h22);
        @(posedge clk);
        #1;
        chk("no queue busy", 32'(busy), 32'd0);
        chk("no queue lo", lo, 32'h22);

        // reserved and none ops do nothing
        run_op(3'd7, 32'h1234, 32'h5, m_hi, m_lo, "op7");
        run_op(3'd0, 32'h1234, 32'h5, m_hi, m_lo, "op0");

        run_op(3'd5, 32'hAAAA0000, 32'd0, 32'hAAAA0000, m_lo, "mthi rd");
        run_op(3'd6, 32'h0000BBBB, 32'd0, m_hi, 32'h0000BBBB, "mtlo rd");
        rd_sel = 1'b0;
        #1;
        chk("rd sel0", rd_data, 32'h0000BBBB);
        rd_sel = 1'b1;
        #1;
        chk("rd sel1", rd_data, 32'hAAAA0000);
        rd_sel = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            model(ro, ra, rb, m_hi, m_lo, eh, el);
            run_op(ro, ra, rb, eh, el, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath.
- Executes mult, multu, div, divu, mthi and mtlo.
- Holds `busy` while an operation is in flight so the controller can stall.
- Drives a 32-bit read port (`rd_data`) that feeds input x3 of the 4:1 write-back data mux.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  operation request, sampled at the rising edge.
- op  in  3  operation code:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved
- a  in  32  operand rs.
- b  in  32  operand rt.
- rd_sel  in  1  read-port select: 0 = LO, 1 = HI.
- busy  out  1  high while a mult/div is in flight.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
- rd_data  out  32  combinational: `rd_sel ? hi : lo`.

Behaviour:
- Reset (reset == 0, asynchronous):
  - hi = 0, lo = 0, busy = 0, internal counter = 0, pending results = 0.
  - Reset asserted mid-operation aborts it; no HI/LO update ever occurs for the aborted operation.
- States: IDLE (counter == 0) and RUN (counter != 0). `busy` is registered and equals (state == RUN).
- IDLE, start == 1 at edge k, op in {001..100}:
  - Compute the result from a and b.
  - Latch it into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - busy = 1 after edge k.
- RUN:
  - Counter decrements at each edge.
  - At the edge where the counter goes 1 -> 0: hi <= pending_hi, lo <= pending_lo, busy <= 0.
  - Net effect: busy is high for exactly N cycles, and the new HI/LO are visible after edge k+N.
  - HI/LO keep their old values throughout RUN.
- IDLE, start == 1, op == 101: hi <= a at edge k. lo is unchanged and busy stays 0.
- IDLE, start == 1, op == 110: lo <= a at edge k. hi is unchanged and busy stays 0.
- start == 1 with op 000 or 111: no effect.
- start == 1 during RUN (any op): ignored. The controller guarantees stall; the unit never queues requests.
- Arithmetic:
  - mult: {hi,lo} = signed(a) * signed(b), 64-bit.
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - b == 0 on div/divu: full latency still applies (busy for DIV_CYCLES). hi/lo are NOT modified at completion (pending_hi/lo loaded with the current hi/lo).
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000; no trap.
- rd_data is purely combinational from hi/lo and rd_sel, with no added latency.
- During RUN, rd_data returns the old HI/LO values. Read-after-mult hazards are the controller's responsibility via `busy`.

Test Plan:
- Reset check: pulse reset low mid-cycle -> hi = lo = 0 and busy = 0 immediately. Then start mult a=3, b=4, and pull reset low at cycle 2 -> busy drops, hi = lo = 0 after release, no late update.
- Signed mult: a=0xFFFFFFFE (-2), b=0x00000003 at edge k.
  - busy = 1 for cycles k+1..k+5.
  - hi = 0xFFFFFFFF, lo = 0xFFFFFFFA after edge k+5.
  - hi/lo unchanged before edge k+5.
- multu/divu: multu 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Then divu 100/7 -> busy 10 cycles, lo = 14, hi = 2.
- Signed div and overflow:
  - div -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Divide by zero and ignored start: preload hi=0x11, lo=0x22 via mthi/mtlo.
  - Check that mthi/mtlo complete in one cycle with busy = 0.
  - div a=5, b=0 -> busy 10 cycles, hi/lo remain 0x11/0x22.
  - Issue mult during RUN -> ignored, busy ends on schedule.
- Read port: hi = 0xAAAA0000, lo = 0x0000BBBB -> rd_sel=0 gives 0x0000BBBB and rd_sel=1 gives 0xAAAA0000, both in the same cycle.
